mc_controller_v2: RTL and testbench
===================================

MC_CONTROLLER_V2 -- requirements
Module: mc_controller_v2

Interface
REQ-001 The block SHALL have parameter ALUOP_W, default 4, width of the ALUop output.
REQ-002 The block SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, the maximum number of consecutive mem_ready-low cycles tolerated in any memory state.
REQ-004 The block SHALL have the following ports:
  - clock  in  1  sole clock, rising edge.
  - reset  in  1  asynchronous, active-low reset.
  - opcode  in  6  instruction opcode from IR.
  - mem_ready  in  1  memory completes the access this cycle.
  - mem_req  out  1  memory access request.
  - IRwrite, MemWrite, MemtoReg, RegWrite, PCwrite, PCwritecond, RegDst, branch  out  1 each  datapath controls.
  - ALUsrcA, ALUsrcB, PCsource  out  2 each  mux selects.
  - ALUop  out  ALUOP_W  ALU operation.
  - state  out  4  current state code.
  - halted  out  1  HALT state reached.
  - fault  out  1  illegal opcode or memory timeout.
  - retired  out  CNT_W  retired-instruction count.

Function
REQ-005 State codes SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXE=6, RWB=7, IEXE=8, IWB=9, BR=10, JMP=11, HALT=12, FAULT=13.
REQ-006 The FSM SHALL be Moore-style except for the mem_ready gating in REQ-007; all outputs not listed for a state SHALL be 0.
REQ-007 In FETCH, mem_req=1, ALUsrcA=0, ALUsrcB=1, ALUop=0 (ADD), and IRwrite=PCwrite=mem_ready; next state is DECODE when mem_ready=1, else FETCH.
REQ-008 In DECODE, ALUsrcA=0, ALUsrcB=3, ALUop=0; next state depends on opcode: 0x00->REXE; 0x23 or 0x2B->MEMADR; 0x04 or 0x05->BR; 0x02->JMP; 0x08, 0x0C or 0x0D->IEXE; 0x3F->HALT; any other value->FAULT.
REQ-009 In MEMADR, ALUsrcA=1, ALUsrcB=2, ALUop=0; next state is MEMRD for 0x23, MEMWR for 0x2B, using the opcode sampled in DECODE.
REQ-010 In MEMRD, mem_req=1; the FSM SHALL wait for mem_ready=1, then go to MEMWB.
REQ-011 In MEMWB, RegWrite=1, MemtoReg=1, RegDst=0; next state is FETCH.
REQ-012 In MEMWR, mem_req=1 and MemWrite=1; the FSM SHALL wait for mem_ready=1, then go to FETCH.
REQ-013 In REXE, ALUsrcA=1, ALUsrcB=0, ALUop=all ones (funct-decoded); next state is RWB.
REQ-014 In RWB, RegWrite=1, RegDst=1, MemtoReg=0; next state is FETCH.
REQ-015 In IEXE, ALUsrcA=1, ALUsrcB=2, and ALUop SHALL be 0 for 0x08, 2 for 0x0C and 3 for 0x0D; next state is IWB.
REQ-016 In IWB, RegWrite=1, RegDst=0, MemtoReg=0; next state is FETCH.
REQ-017 In BR, ALUsrcA=1, ALUsrcB=0, ALUop=1 (SUB), PCwritecond=1, PCsource=1, and branch=1 for 0x05 (BNE) or 0 for 0x04 (BEQ); next state is FETCH.
REQ-018 In JMP, PCwrite=1 and PCsource=2; next state is FETCH.
REQ-019 HALT SHALL be absorbing, with halted=1 and all datapath controls 0.
REQ-020 FAULT SHALL be absorbing, with fault=1 and all datapath controls 0.
REQ-021 A wait counter SHALL clear on entry to each memory state (FETCH, MEMRD, MEMWR) and increment each cycle mem_ready=0 there; if it reaches TIMEOUT with mem_ready still 0, next state SHALL be FAULT.
REQ-022 If mem_ready=1 in the same cycle the counter reaches TIMEOUT, mem_ready SHALL win and the normal transition is taken.
REQ-023 retired SHALL increment by 1 on every transition into FETCH from MEMWB, MEMWR, RWB, IWB, BR or JMP.
REQ-024 retired SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 The opcode latched in DECODE SHALL be held until the next DECODE, so that changes on the opcode input after DECODE have no effect.

Reset
REQ-026 reset=0 SHALL immediately force state=FETCH, retired=0, wait counter=0, halted=0, fault=0 and the latched opcode=0, without waiting for a clock edge.
REQ-027 Reset asserted in any state, including HALT, FAULT or mid-wait, SHALL abort the operation.
REQ-028 After reset deasserts, the first clock edge SHALL evaluate FETCH normally.

Verification
REQ-029 Opcode 0x00, mem_ready always 1 -> states 0,1,6,7,0 on consecutive cycles, RegWrite=1 and RegDst=1 only in RWB, retired=1.
REQ-030 Opcode 0x23, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles with mem_req=1, then MEMWB with MemtoReg=1, retired=1.
REQ-031 Opcode 0x05 -> BR with PCwritecond=1, branch=1, PCsource=1, ALUop=1.
REQ-032 Opcode 0x3F -> HALT with halted=1; further clocks leave state=12 and retired unchanged.
REQ-033 Opcode 0x11 -> FAULT; separately, mem_ready held 0 in FETCH -> FAULT after exactly TIMEOUT+1 cycles; mem_ready=1 on the TIMEOUT cycle -> DECODE.
REQ-034 With CNT_W=2, retire 5 instructions -> retired=3; assert reset mid-MEMWR -> state=0 and retired=0 asynchronously.

Source files
------------

// File: rtl/mc_controller_v2.sv
// mc_controller_v2: multicycle CPU control FSM with a memory-wait timeout and a
// saturating retired-instruction counter.
//
// Ports:
//   clock, reset (async, active-low)
//   opcode[5:0]   instruction opcode from IR, latched in DECODE
//   mem_ready     memory completes the access this cycle
//   mem_req       memory access request (FETCH, MEMRD, MEMWR)
//   IRwrite, MemWrite, MemtoReg, RegWrite, PCwrite, PCwritecond, RegDst, branch
//   ALUsrcA, ALUsrcB, PCsource (2 bits each), ALUop (ALUOP_W bits)
//   state[3:0]    current state code
//   halted, fault HALT / FAULT reached (both absorbing until reset)
//   retired       saturating count of completed instructions
module mc_controller_v2 #(
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               IRwrite,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               PCwrite,
    output logic               PCwritecond,
    output logic               RegDst,
    output logic               branch,
    output logic [1:0]         ALUsrcA,
    output logic [1:0]         ALUsrcB,
    output logic [1:0]         PCsource,
    output logic [ALUOP_W-1:0] ALUop,
    output logic [3:0]         state,
    output logic               halted,
    output logic               fault,
    output logic [CNT_W-1:0]   retired
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] REXE   = 4'd6;
    localparam logic [3:0] RWB    = 4'd7;
    localparam logic [3:0] IEXE   = 4'd8;
    localparam logic [3:0] IWB    = 4'd9;
    localparam logic [3:0] BR     = 4'd10;
    localparam logic [3:0] JMP    = 4'd11;
    localparam logic [3:0] HALT   = 4'd12;
    localparam logic [3:0] FAULT  = 4'd13;

    // Wide enough to hold TIMEOUT itself.
    localparam int WAIT_W = $clog2(TIMEOUT + 2);

    logic [3:0]        state_q, state_d;
    logic [5:0]        op_q, op_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              in_mem_state;
    logic              timed_out;
    logic              retire;

    assign in_mem_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    // mem_ready has priority: timeout only when the access is still pending.
    assign timed_out    = (wait_q == WAIT_W'(TIMEOUT)) && !mem_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH: begin
                if (mem_ready)      state_d = DECODE;
                else if (timed_out) state_d = FAULT;
            end
            DECODE: begin
                case (opcode)
                    6'h00:               state_d = REXE;
                    6'h23, 6'h2B:        state_d = MEMADR;
                    6'h04, 6'h05:        state_d = BR;
                    6'h02:               state_d = JMP;
                    6'h08, 6'h0C, 6'h0D: state_d = IEXE;
                    6'h3F:               state_d = HALT;
                    default:             state_d = FAULT;
                endcase
            end
            MEMADR: state_d = (op_q == 6'h2B) ? MEMWR : MEMRD;
            MEMRD: begin
                if (mem_ready)      state_d = MEMWB;
                else if (timed_out) state_d = FAULT;
            end
            MEMWR: begin
                if (mem_ready)      state_d = FETCH;
                else if (timed_out) state_d = FAULT;
            end
            MEMWB, RWB, IWB, BR, JMP: state_d = FETCH;
            REXE:        state_d = RWB;
            IEXE:        state_d = IWB;
            HALT, FAULT: state_d = state_q;
            default:     state_d = FAULT;
        endcase
    end

    always_comb begin
        // Any state change is an entry into a new state, so the counter restarts.
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (in_mem_state && !mem_ready) begin
            wait_d = wait_q + WAIT_W'(1);
        end else begin
            wait_d = wait_q;
        end

        op_d = (state_q == DECODE) ? opcode : op_q;

        retire = (state_d == FETCH) &&
                 ((state_q == MEMWB) || (state_q == MEMWR) || (state_q == RWB) ||
                  (state_q == IWB) || (state_q == BR) || (state_q == JMP));
        retired_d = (retire && (retired_q != '1)) ? retired_q + CNT_W'(1) : retired_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            op_q      <= '0;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        mem_req     = 1'b0;
        IRwrite     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        PCwrite     = 1'b0;
        PCwritecond = 1'b0;
        RegDst      = 1'b0;
        branch      = 1'b0;
        ALUsrcA     = 2'd0;
        ALUsrcB     = 2'd0;
        PCsource    = 2'd0;
        ALUop       = '0;
        unique case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                ALUsrcB = 2'd1;
                IRwrite = mem_ready;
                PCwrite = mem_ready;
            end
            DECODE: ALUsrcB = 2'd3;
            MEMADR: begin
                ALUsrcA = 2'd1;
                ALUsrcB = 2'd2;
            end
            MEMRD: mem_req = 1'b1;
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
            end
            REXE: begin
                ALUsrcA = 2'd1;
                ALUop   = '1;
            end
            RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            IEXE: begin
                ALUsrcA = 2'd1;
                ALUsrcB = 2'd2;
                if (op_q == 6'h0C)      ALUop = ALUOP_W'(2);
                else if (op_q == 6'h0D) ALUop = ALUOP_W'(3);
            end
            IWB: RegWrite = 1'b1;
            BR: begin
                ALUsrcA     = 2'd1;
                ALUop       = ALUOP_W'(1);
                PCwritecond = 1'b1;
                PCsource    = 2'd1;
                branch      = (op_q == 6'h05);
            end
            JMP: begin
                PCwrite  = 1'b1;
                PCsource = 2'd2;
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign halted  = (state_q == HALT);
    assign fault   = (state_q == FAULT);
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_controller_v2.sv
module tb_mc_controller_v2;

    localparam int CW      = 2;
    localparam int TMO     = 15;
    localparam int RET_MAX = (1 << CW) - 1;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4;
    localparam int S_MEMWR = 5, S_REXE = 6, S_RWB = 7, S_IEXE = 8, S_IWB = 9;
    localparam int S_BR = 10, S_JMP = 11, S_HALT = 12, S_FAULT = 13;

    logic          clock = 1'b0;
    logic          reset;
    logic [5:0]    opcode;
    logic          mem_ready;
    logic          mem_req, IRwrite, MemWrite, MemtoReg, RegWrite, PCwrite, PCwritecond;
    logic          RegDst, branch, halted, fault;
    logic [1:0]    ALUsrcA, ALUsrcB, PCsource;
    logic [3:0]    ALUop;
    logic [3:0]    state;
    logic [CW-1:0] retired;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    mc_controller_v2 #(.ALUOP_W(4), .CNT_W(CW), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .IRwrite(IRwrite), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .PCwrite(PCwrite), .PCwritecond(PCwritecond),
        .RegDst(RegDst), .branch(branch), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB),
        .PCsource(PCsource), .ALUop(ALUop), .state(state), .halted(halted),
        .fault(fault), .retired(retired)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-state control table and instruction-level sequencing.
    int         m_state = S_FETCH;
    logic [5:0] m_op    = 6'h00;
    int         m_wait  = 0;
    int         m_ret   = 0;

    function automatic int decode_next(input logic [5:0] op);
        case (op)
            6'h00:               return S_REXE;
            6'h23, 6'h2B:        return S_MEMADR;
            6'h04, 6'h05:        return S_BR;
            6'h02:               return S_JMP;
            6'h08, 6'h0C, 6'h0D: return S_IEXE;
            6'h3F:               return S_HALT;
            default:             return S_FAULT;
        endcase
    endfunction

    // {mem_req,IRwrite,MemWrite,MemtoReg,RegWrite,PCwrite,PCwritecond,RegDst,branch,
    //  ALUsrcA,ALUsrcB,PCsource,ALUop,halted,fault}
    function automatic logic [20:0] exp_out(input int st, input logic [5:0] op, input logic mr);
        logic [8:0] f;
        logic [1:0] a, b, p;
        logic [3:0] alu;
        f = '0; a = 0; b = 0; p = 0; alu = 0;
        case (st)
            S_FETCH:  begin f[8] = 1; f[7] = mr; f[3] = mr; b = 1; end
            S_DECODE: b = 3;
            S_MEMADR: begin a = 1; b = 2; end
            S_MEMRD:  f[8] = 1;
            S_MEMWB:  begin f[4] = 1; f[5] = 1; end
            S_MEMWR:  begin f[8] = 1; f[6] = 1; end
            S_REXE:   begin a = 1; alu = 4'hF; end
            S_RWB:    begin f[4] = 1; f[1] = 1; end
            S_IEXE:   begin a = 1; b = 2; alu = (op == 6'h0C) ? 4'd2 : (op == 6'h0D) ? 4'd3 : 4'd0; end
            S_IWB:    f[4] = 1;
            S_BR:     begin a = 1; alu = 1; f[2] = 1; p = 1; f[0] = (op == 6'h05); end
            S_JMP:    begin f[3] = 1; p = 2; end
            default:  ;
        endcase
        return {f, a, b, p, alu, st == S_HALT, st == S_FAULT};
    endfunction

    always @(posedge clock or negedge reset) begin
        int nxt;
        if (!reset) begin
            m_state <= S_FETCH;
            m_op    <= 6'h00;
            m_wait  <= 0;
            m_ret   <= 0;
        end else begin
            nxt = m_state;
            case (m_state)
                S_FETCH, S_MEMRD, S_MEMWR: begin
                    if (mem_ready)
                        nxt = (m_state == S_FETCH) ? S_DECODE :
                              (m_state == S_MEMRD) ? S_MEMWB : S_FETCH;
                    else if (m_wait == TMO)
                        nxt = S_FAULT;
                end
                S_DECODE: nxt = decode_next(opcode);
                S_MEMADR: nxt = (m_op == 6'h2B) ? S_MEMWR : S_MEMRD;
                S_REXE:   nxt = S_RWB;
                S_IEXE:   nxt = S_IWB;
                S_HALT, S_FAULT: nxt = m_state;
                default:  nxt = S_FETCH;
            endcase
            if (nxt != m_state) m_wait <= 0;
            else if (!mem_ready) m_wait <= m_wait + 1;
            if (m_state == S_DECODE) m_op <= opcode;
            if (nxt == S_FETCH && m_state != S_FETCH && m_ret < RET_MAX) m_ret <= m_ret + 1;
            m_state <= nxt;
        end
    end

    always @(negedge clock) begin
        if (chk_en && reset) begin
            check("state", 32'(state), 32'(m_state));
            check("ctrl", 32'({mem_req, IRwrite, MemWrite, MemtoReg, RegWrite, PCwrite,
                               PCwritecond, RegDst, branch, ALUsrcA, ALUsrcB, PCsource,
                               ALUop, halted, fault}),
                  32'(exp_out(m_state, m_op, mem_ready)));
            check("retired", 32'(retired), 32'(m_ret));
        end
    end

    task automatic tick();
        @(posedge clock);
        #4;
    endtask

    initial begin
        reset = 1'b1; opcode = 6'h00; mem_ready = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_retired", 32'(retired), 0);
        check("rst_flags", 32'({halted, fault}), 0);
        tick(); tick();
        reset = 1'b1; chk_en = 1'b1;

        // R-type: 0,1,6,7,0
        check("r_s0", 32'(state), 0); tick();
        check("r_s1", 32'(state), 1); tick();
        check("r_s6", 32'(state), 6); check("r_rw_exe", 32'(RegWrite), 0); tick();
        check("r_s7", 32'(state), 7); check("r_rw_dst", 32'({RegWrite, RegDst}), 3); tick();
        check("r_s0b", 32'(state), 0); check("r_ret", 32'(retired), 1);

        // LW with 3 wait cycles; opcode changes after DECODE are ignored
        opcode = 6'h23; tick();
        tick();
        check("lw_adr", 32'(state), 2);
        opcode = 6'h2B; mem_ready = 1'b0; tick();
        for (int i = 0; i < 4; i++) begin
            check("lw_rd", 32'({state, mem_req}), 32'({4'd3, 1'b1}));
            if (i == 3) mem_ready = 1'b1;
            tick();
        end
        check("lw_wb", 32'({state, MemtoReg}), 32'({4'd4, 1'b1})); tick();
        check("lw_ret", 32'(retired), 2);

        // BNE
        opcode = 6'h05; tick(); tick();
        check("bne", 32'({state, PCwritecond, branch, PCsource, ALUop}),
              32'({4'd10, 1'b1, 1'b1, 2'd1, 4'd1}));
        tick();
        check("bne_ret", 32'(retired), 3);

        // JMP then ORI: retired saturates at 3
        opcode = 6'h02; tick(); tick();
        check("jmp", 32'({state, PCwrite, PCsource}), 32'({4'd11, 1'b1, 2'd2}));
        tick();
        opcode = 6'h0D; tick(); tick();
        check("ori", 32'({state, ALUop}), 32'({4'd8, 4'd3}));
        tick(); tick();
        check("sat_ret", 32'(retired), 3);

        // Reset asserted mid-MEMWR acts without a clock edge
        opcode = 6'h2B; tick(); tick();
        mem_ready = 1'b0; tick();
        check("sw_wr", 32'({state, MemWrite}), 32'({4'd5, 1'b1}));
        tick();
        reset = 1'b0; chk_en = 1'b0;
        #1;
        check("async_state", 32'(state), 0);
        check("async_ret", 32'(retired), 0);
        mem_ready = 1'b1; opcode = 6'h11; tick();
        reset = 1'b1; chk_en = 1'b1;

        // Illegal opcode
        tick(); tick();
        check("ill", 32'({state, fault}), 32'({4'd13, 1'b1}));
        tick(); tick();
        check("ill_hold", 32'(state), 13);
        reset = 1'b0; #1;
        check("ill_rst", 32'(fault), 0);
        opcode = 6'h3F; tick();
        reset = 1'b1;

        // HALT
        tick(); tick();
        check("halt", 32'({state, halted}), 32'({4'd12, 1'b1}));
        tick(); tick();
        check("halt_hold", 32'({state, retired}), 32'({4'd12, 2'd0}));
        reset = 1'b0; mem_ready = 1'b0; tick();
        reset = 1'b1;

        // Timeout in FETCH: TIMEOUT+1 cycles then FAULT
        for (int i = 0; i <= TMO; i++) begin
            check("tmo_wait", 32'(state), 0);
            tick();
        end
        check("tmo_fault", 32'(state), 13);
        reset = 1'b0; tick();
        reset = 1'b1;

        // mem_ready on the TIMEOUT cycle wins
        for (int i = 0; i < TMO; i++) tick();
        check("tmo_edge_wait", 32'(state), 0);
        mem_ready = 1'b1; tick();
        check("tmo_edge_dec", 32'(state), 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
